// File: rtl/apb_master.sv
// APB3 requester: turns valid/ready commands into single APB transfers with a one-cycle response.
// Optional access watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    output logic [31:0]       pwdata,
    input  logic [31:0]       prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t r_state;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_wait_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    // Held low during reset so nothing is accepted while the bus is being cleared.
    assign cmd_ready = reset_n & enable & (r_state == IDLE);

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
        end else if (enable) begin
            rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        paddr   <= cmd_addr;
                        pwrite  <= cmd_write;
                        pwdata  <= cmd_write ? cmd_wdata : 32'h0;
                        psel    <= 1'b1;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    r_state <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                ACCESS: begin
                    // A ready responder always wins over the watchdog on the same edge.
                    if (pready) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= pslverr;
                        rsp_rdata <= pwrite ? 32'h0 : prdata;
                        r_state   <= IDLE;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (r_wait_cnt == CNT_LAST) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'h0;
                        r_state   <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed and randomized APB transfers against a transaction-level model.
module tb_apb_master;

    localparam int ADDR_W = 5;

    logic              pclk = 1'b0;
    logic              reset_n = 1'b1;
    logic              enable = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [31:0]       cmd_wdata = '0;
    logic [31:0]       prdata = '0;
    logic              pready = 1'b0;
    logic              pslverr = 1'b0;
    logic              cmd_ready;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [31:0]       pwdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    apb_master #(.ADDR_W(ADDR_W), .TIMEOUT(4)) dut (
        .pclk(pclk), .reset_n(reset_n), .enable(enable),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_psel"},    32'(psel), 0);
        check({tag, "_penable"}, 32'(penable), 0);
        check({tag, "_rsp_vld"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 0);
        check({tag, "_rdata"},   rsp_rdata, 0);
        check({tag, "_paddr"},   32'(paddr), 0);
        check({tag, "_pwrite"},  32'(pwrite), 0);
        check({tag, "_pwdata"},  pwdata, 0);
        check({tag, "_cmd_rdy"}, 32'(cmd_ready), 0);
    endtask

    // Transaction-level model: a transfer with `waits` not-ready ACCESS cycles completes
    // 2+waits edges after acceptance; response data is prdata for reads and 0 for writes.
    task automatic do_xfer(input logic wr, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                           input int waits, input logic [31:0] rd, input logic err);
        logic [31:0] exp_pw;
        logic [31:0] exp_rd;
        exp_pw = wr ? wd : 32'h0;
        exp_rd = wr ? 32'h0 : rd;
        check("idle_ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
        pready = 1'($urandom);
        tick;
        cmd_valid = 1'b0; cmd_write = 1'($urandom);
        cmd_addr = ADDR_W'($urandom); cmd_wdata = $urandom;
        check("setup_psel", 32'(psel), 1);
        check("setup_penable", 32'(penable), 0);
        check("setup_paddr", 32'(paddr), 32'(a));
        check("setup_pwrite", 32'(pwrite), 32'(wr));
        check("setup_pwdata", pwdata, exp_pw);
        check("setup_ready", 32'(cmd_ready), 0);
        pready = 1'($urandom);
        tick;
        check("access_psel", 32'(psel), 1);
        check("access_penable", 32'(penable), 1);
        for (int n = 0; n < waits; n++) begin
            pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
            tick;
            check("wait_penable", 32'(penable), 1);
            check("wait_rsp_valid", 32'(rsp_valid), 0);
            check("wait_paddr", 32'(paddr), 32'(a));
            check("wait_pwdata", pwdata, exp_pw);
        end
        pready = 1'b1; prdata = rd; pslverr = err;
        tick;
        check("done_rsp_valid", 32'(rsp_valid), 1);
        check("done_rsp_err", 32'(rsp_err), 32'(err));
        check("done_rdata", rsp_rdata, exp_rd);
        check("done_psel", 32'(psel), 0);
        check("done_penable", 32'(penable), 0);
        check("done_ready", 32'(cmd_ready), 1);
        check("done_paddr_hold", 32'(paddr), 32'(a));
        pready = 1'b0; prdata = $urandom; pslverr = 1'b0;
        tick;
        check("after_rsp_valid", 32'(rsp_valid), 0);
        check("after_rdata_hold", rsp_rdata, exp_rd);
        check("after_err_hold", 32'(rsp_err), 32'(err));
    endtask

    initial begin
        int t[$];
        int last;
        int acc;
        int hold;
        logic got;

        #1 reset_n = 1'b0;
        #1;
        check_all_zero("reset");
        tick;
        tick;
        reset_n = 1'b1;
        #1;
        check("post_reset_ready", 32'(cmd_ready), 1);

        do_xfer(1'b1, 5'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0);
        do_xfer(1'b0, 5'h1C, 32'h0, 2, 32'h00216948, 1'b0);
        do_xfer(1'b1, 5'h04, 32'hA5A55A5A, 1, 32'h0, 1'b1);
        do_xfer(1'b0, 5'h08, 32'h0, 0, 32'hCAFEF00D, 1'b0);

        for (int i = 0; i < 20; i++)
            do_xfer(1'($urandom), ADDR_W'($urandom), $urandom, $urandom_range(0, 3),
                    $urandom, 1'($urandom));

        // Continuous commands: one completion every 3 cycles.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'h0A; cmd_wdata = 32'h12345678;
        pready = 1'b1; pslverr = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick;
            if (rsp_valid) t.push_back(cyc);
        end
        check("b2b_count", 32'(t.size()), 3);
        if (t.size() == 3) begin
            check("b2b_gap1", 32'(t[1] - t[0]), 3);
            check("b2b_gap2", 32'(t[2] - t[1]), 3);
        end
        last = (t.size() > 0) ? t[t.size() - 1] : 0;
        tick;
        check("b2b_setup_psel", 32'(psel), 1);
        tick;
        check("b2b_access_penable", 32'(penable), 1);
        enable = 1'b0;
        #1;
        check("gated_ready", 32'(cmd_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("gated_psel", 32'(psel), 1);
            check("gated_penable", 32'(penable), 1);
            check("gated_rsp_valid", 32'(rsp_valid), 0);
            check("gated_paddr", 32'(paddr), 32'h0A);
            check("gated_pwdata", pwdata, 32'h12345678);
        end
        enable = 1'b1;
        tick;
        check("gated_done", 32'(rsp_valid), 1);
        check("gated_extra_cycles", 32'(cyc - last), 6);
        cmd_valid = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick;
            check("stretch_rsp_valid", 32'(rsp_valid), 1);
        end
        enable = 1'b1;
        tick;
        check("stretch_end", 32'(rsp_valid), 0);
        pready = 1'b0;
        tick;

`ifdef APB_MASTER_TIMEOUT_EN
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h14;
        tick;
        cmd_valid = 1'b0; pready = 1'b0;
        acc = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            prdata = $urandom | 32'h1;
            tick;
            if (rsp_valid) got = 1'b1;
            else if (penable) acc++;
        end
        check("to_fired", 32'(got), 1);
        check("to_access_cycles", 32'(acc), 4);
        check("to_err", 32'(rsp_err), 1);
        check("to_rdata", rsp_rdata, 0);
        check("to_psel", 32'(psel), 0);
        tick;
        do_xfer(1'b0, 5'h18, 32'h0, 3, 32'h0BADF00D, 1'b0);
`else
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h14;
        tick;
        cmd_valid = 1'b0; pready = 1'b0;
        tick;
        hold = 0;
        for (int i = 0; i < 120; i++) begin
            tick;
            if (psel && penable && !rsp_valid) hold++;
        end
        check("no_to_hold", 32'(hold), 120);
        pready = 1'b1; prdata = 32'h55AA00FF;
        tick;
        check("no_to_done", 32'(rsp_valid), 1);
        check("no_to_rdata", rsp_rdata, 32'h55AA00FF);
        pready = 1'b0;
        tick;
`endif

        // Reset in the middle of ACCESS.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'h1F; cmd_wdata = 32'hFFFF0001;
        tick;
        cmd_valid = 1'b0; pready = 1'b0;
        tick;
        tick;
        check("pre_rst_penable", 32'(penable), 1);
        #3 reset_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        tick;
        tick;
        reset_n = 1'b1;
        #1;
        check("rst_release_ready", 32'(cmd_ready), 1);
        pready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (rsp_valid || psel) got = 1'b1;
        end
        check("rst_no_rsp", 32'(got), 0);
        pready = 1'b0;
        do_xfer(1'b0, 5'h02, 32'h0, 1, 32'h13579BDF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that converts a simple valid/ready command interface into single APB3 transfers and returns a one-cycle response with read data and error status. It sits between an internal controller or test sequencer and the APB register slaves on the peripheral bus. It drives the setup and access phases, inserts wait states while `pready` is low, and reports `pslverr`. An optional watchdog aborts transfers whose responder never completes.

## Interface
- `ADDR_W`, 5, width of `cmd_addr`/`paddr`.
- `TIMEOUT`, 16, maximum ACCESS cycles before abort (used only with the timeout feature); must be ≥ 2.
- `pclk`  in  1  APB clock; all logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  clock gate; when low, all state and outputs hold.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted on a cycle where `cmd_valid & cmd_ready`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W  byte address.
- `cmd_wdata`  in  32  write data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  32  read data; 0 for writes and aborts.
- `rsp_err`  out  1  `pslverr` or timeout, qualified by `rsp_valid`.
- `paddr`  out  ADDR_W  APB address.
- `pwrite`  out  1  APB direction.
- `psel`  out  1  APB select.
- `penable`  out  1  APB enable.
- `pwdata`  out  32  APB write data; 0 for reads.
- `prdata`  in  32  APB read data.
- `pready`  in  1  APB ready.
- `pslverr`  in  1  APB error.

## Operation
- States: IDLE, SETUP, ACCESS. Encoding is free.
- `cmd_ready` = (state == IDLE) & `enable`. It is combinational from state only, not from `cmd_valid`.
- IDLE: when `cmd_valid` is high at the edge, register `paddr`, `pwrite`, and `pwdata` (forced to 0 for reads). Set `psel`=1 and go to SETUP.
- SETUP: at the next edge, set `penable`=1 and go to ACCESS. `pready` is ignored in SETUP.
- ACCESS: at each edge, if `pready`=1, the transfer completes:
  - `psel`=`penable`=0, state goes to IDLE.
  - `rsp_valid`=1 for one cycle.
  - `rsp_err`=`pslverr`.
  - `rsp_rdata`=`prdata` for reads, 0 for writes.
- `paddr`, `pwrite`, and `pwdata` stay stable from SETUP until completion. After completion they hold their last value.
- There is no back-to-back ACCESS→SETUP. Every transfer passes through IDLE, so the minimum period is 3 cycles.
- `rsp_rdata` and `rsp_err` hold until the next completion.
- `enable` low freezes the FSM, counter, and every registered output, including an asserted `rsp_valid`. This stretches the pulse and is intended for gated clocks.
- Reset, including mid-transfer, immediately forces every output to 0 and the state to IDLE. No response is issued for the aborted transfer.

## Timing
- Command accepted at edge N: `psel`=1 from N. `penable`=1 from N+1.
- Zero-wait-state slave: completes at edge N+2. `rsp_valid` is high N+2..N+3, and `cmd_ready` is high again from N+2.
- Each cycle `pready` is low in ACCESS adds one cycle.
- Read data is sampled only at the completing edge.
- Reset values: `cmd_ready`=0 while in reset, 1 after. All other outputs are 0.

## Configuration
- `APB_MASTER_TIMEOUT_EN` defined:
  - An internal counter of width clog2(TIMEOUT) clears on entry to ACCESS and increments on each ACCESS edge with `pready`=0.
  - When the counter equals TIMEOUT−1 and `pready`=0 at an edge, the transfer aborts. That edge gives `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0, and `psel`=`penable`=0, with state going to IDLE.
  - ACCESS therefore lasts at most TIMEOUT cycles.
  - If `pready`=1 on that same edge, normal completion wins.
- `APB_MASTER_TIMEOUT_EN` undefined: there is no counter, `TIMEOUT` is unused, and ACCESS waits indefinitely for `pready`.

## Test plan
- Write with `pready` tied to 1: command write, addr 0x10, data 0xDEADBEEF, accepted at edge N.
  - `psel` is high N..N+2 and `penable` is high N+1..N+2.
  - `paddr`=0x10 and `pwdata`=0xDEADBEEF throughout.
  - `rsp_valid` pulses at N+2 with `rsp_err`=0 and `rsp_rdata`=0.
- Read, addr 0x1C, with `pready` low for 2 ACCESS cycles, then `prdata`=0x00216948 with `pready`=1 → completes at N+4 with `rsp_rdata`=0x00216948.
- Write with `pslverr`=1 at completion → `rsp_err`=1 for that response. The next error-free read gives `rsp_err`=0.
- Timeout, with the macro defined and TIMEOUT=4, and `pready` held low → ACCESS lasts exactly 4 cycles; abort gives `rsp_err`=1 and `rsp_rdata`=0. Without the macro, `psel` stays high for 100+ cycles.
- Reset during ACCESS → `psel`, `penable`, and `rsp_valid` drop to 0 asynchronously. After release, `cmd_ready`=1 and no response is issued.
- `cmd_valid` held high continuously, and `enable` low for 3 cycles during ACCESS:
  - Transfers repeat every 3 cycles.
  - The enable-low window holds every output and adds exactly 3 cycles.
